// File: rtl/cic_comb_chain.sv
// Cascaded CIC comb section: N_STAGES registered differentiators y[n] = x[n] - x[n-M],
// time-multiplexed over N_CH channels, with wrap or saturating arithmetic and a sticky overflow flag.
module cic_comb_chain #(
    parameter int WIDTH      = 16,
    parameter int N_STAGES   = 3,
    parameter int DIFF_DELAY = 1,
    parameter int N_CH       = 1,
    parameter int SATURATE   = 0,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    ch_sync,
    input  logic                    ovf_clr,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    overflow
);

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d, in_ch;
    logic [N_STAGES-1:0] stage_ovf;
    logic                overflow_q, overflow_d;

    // Channel tag of the current sample; ch_sync overrides the running count.
    always_comb begin
        in_ch    = ch_sync ? '0 : ch_cnt_q;
        ch_cnt_d = ch_cnt_q;
        if (in_valid) begin
            ch_cnt_d = (in_ch == CH_W'(N_CH - 1)) ? '0 : in_ch + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_cnt_q <= '0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
        end
    end

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        logic                    stg_vld_in;
        logic signed [WIDTH-1:0] x_in;
        logic [CH_W-1:0]         ch_in;
        logic signed [WIDTH-1:0] hist_q [N_CH][DIFF_DELAY];
        logic signed [WIDTH-1:0] hist_d [N_CH][DIFF_DELAY];
        logic signed [WIDTH-1:0] old_x;
        logic signed [WIDTH:0]   diff;
        logic                    ovf;
        logic signed [WIDTH-1:0] res;
        logic                    vld_q, vld_d;
        logic signed [WIDTH-1:0] dat_q, dat_d;
        logic [CH_W-1:0]         chn_q, chn_d;

        if (gi == 0) begin : g_first
            assign stg_vld_in = in_valid;
            assign x_in       = in_data;
            assign ch_in      = in_ch;
        end else begin : g_next
            assign stg_vld_in = g_stage[gi-1].vld_q;
            assign x_in       = g_stage[gi-1].dat_q;
            assign ch_in      = g_stage[gi-1].chn_q;
        end

        always_comb begin
            old_x = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (ch_in == CH_W'(c)) begin
                    old_x = hist_q[c][DIFF_DELAY-1];
                end
            end
            // One guard bit: a sign disagreement between the top two bits means out of range.
            diff = {x_in[WIDTH-1], x_in} - {old_x[WIDTH-1], old_x};
            ovf  = diff[WIDTH] ^ diff[WIDTH-1];
            if (ovf && (SATURATE != 0)) begin
                res = diff[WIDTH] ? S_MIN : S_MAX;
            end else begin
                res = diff[WIDTH-1:0];
            end

            hist_d = hist_q;
            vld_d  = stg_vld_in;
            dat_d  = dat_q;
            chn_d  = chn_q;
            if (stg_vld_in) begin
                dat_d = res;
                chn_d = ch_in;
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_in == CH_W'(c)) begin
                        for (int d = DIFF_DELAY - 1; d > 0; d--) begin
                            hist_d[c][d] = hist_q[c][d-1];
                        end
                        hist_d[c][0] = x_in;
                    end
                end
            end
        end

        assign stage_ovf[gi] = stg_vld_in & ovf;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_q <= 1'b0;
                dat_q <= '0;
                chn_q <= '0;
                for (int c = 0; c < N_CH; c++) begin
                    for (int d = 0; d < DIFF_DELAY; d++) begin
                        hist_q[c][d] <= '0;
                    end
                end
            end else begin
                vld_q  <= vld_d;
                dat_q  <= dat_d;
                chn_q  <= chn_d;
                hist_q <= hist_d;
            end
        end
    end

    // A new overflow wins over a simultaneous clear.
    always_comb begin
        overflow_d = (|stage_ovf) | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = g_stage[N_STAGES-1].vld_q;
    assign out_data  = g_stage[N_STAGES-1].dat_q;
    assign out_ch    = g_stage[N_STAGES-1].chn_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain: four configurations share one stimulus stream; a reference
// model (binomial form of the cascaded comb) fills a scoreboard checked at each negedge.
module tb_cic_comb_chain;

    typedef struct {
        int inst;
        int due;
        int data;
        int ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_d16 = '0;
    logic        ch_sync = 1'b0;
    logic        ovf_clr = 1'b0;

    logic       a_vld, b_vld, c_vld, d_vld;
    logic [7:0] a_dat, b_dat;
    logic [15:0] c_dat, d_dat;
    logic       a_ch, b_ch, c_ch, d_ch;
    logic       a_ovf, b_ovf, c_ovf, d_ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   xh[4][2][8];
    int   m_cnt[4];
    int   last_d[4];
    int   last_c[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 8-bit wrap, B: 8-bit saturate, C: two channels, D: 3 stages with M=2.
    cic_comb_chain #(.WIDTH(8), .N_STAGES(1), .DIFF_DELAY(1), .N_CH(1), .SATURATE(0)) u_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_d16[7:0]), .ch_sync(ch_sync),
        .ovf_clr(ovf_clr), .out_valid(a_vld), .out_data(a_dat), .out_ch(a_ch), .overflow(a_ovf));
    cic_comb_chain #(.WIDTH(8), .N_STAGES(1), .DIFF_DELAY(1), .N_CH(1), .SATURATE(1)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_d16[7:0]), .ch_sync(ch_sync),
        .ovf_clr(ovf_clr), .out_valid(b_vld), .out_data(b_dat), .out_ch(b_ch), .overflow(b_ovf));
    cic_comb_chain #(.WIDTH(16), .N_STAGES(1), .DIFF_DELAY(1), .N_CH(2), .SATURATE(0)) u_c (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_d16), .ch_sync(ch_sync),
        .ovf_clr(ovf_clr), .out_valid(c_vld), .out_data(c_dat), .out_ch(c_ch), .overflow(c_ovf));
    cic_comb_chain #(.WIDTH(16), .N_STAGES(3), .DIFF_DELAY(2), .N_CH(1), .SATURATE(0)) u_d (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_d16), .ch_sync(ch_sync),
        .ovf_clr(ovf_clr), .out_valid(d_vld), .out_data(d_dat), .out_ch(d_ch), .overflow(d_ovf));

    task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: N-stage comb with delay M equals sum_k (-1)^k C(N,k) x[n-kM].
    task automatic push_sample(int x, bit s);
        for (int i = 0; i < 4; i++) begin
            int nch = (i == 2) ? 2 : 1;
            int w   = (i < 2) ? 8 : 16;
            int lat = (i == 3) ? 3 : 1;
            int ch;
            int acc;
            int y;
            ch = s ? 0 : m_cnt[i];
            m_cnt[i] = (ch + 1) % nch;
            for (int k = 7; k > 0; k--) xh[i][ch][k] = xh[i][ch][k-1];
            xh[i][ch][0] = x;
            if (i == 3) acc = xh[i][ch][0] - 3 * xh[i][ch][2] + 3 * xh[i][ch][4] - xh[i][ch][6];
            else        acc = xh[i][ch][0] - xh[i][ch][1];
            if (i == 1) y = (acc > 127) ? 127 : ((acc < -128) ? -128 : acc);
            else        y = (acc <<< (32 - w)) >>> (32 - w);
            sb.push_back('{i, cyc + lat, y, ch});
        end
    endtask

    task automatic mon(int i, logic v, logic signed [31:0] d, logic [31:0] c);
        int idx = -1;
        bit exp_v;
        foreach (sb[k]) if (idx < 0 && sb[k].inst == i) idx = k;
        exp_v = (idx >= 0) && (sb[idx].due <= cyc);
        check($sformatf("out_valid_%0d@%0d", i, cyc), v, exp_v);
        if (v) begin
            if (idx >= 0) begin
                check($sformatf("latency_%0d", i), cyc, sb[idx].due);
                check($sformatf("out_data_%0d", i), d, sb[idx].data);
                check($sformatf("out_ch_%0d", i), c, sb[idx].ch);
                $display("inst %0d cyc %0d out_data %0d out_ch %0d", i, cyc, d, c);
                sb.delete(idx);
            end
            last_d[i] = d;
            last_c[i] = c;
        end else begin
            check($sformatf("hold_data_%0d", i), d, last_d[i]);
            check($sformatf("hold_ch_%0d", i), c, last_c[i]);
            if (exp_v) sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            mon(0, a_vld, $signed(a_dat), 32'(a_ch));
            mon(1, b_vld, $signed(b_dat), 32'(b_ch));
            mon(2, c_vld, $signed(c_dat), 32'(c_ch));
            mon(3, d_vld, $signed(d_dat), 32'(d_ch));
        end
    end

    task automatic step(bit v, int x, bit s, bit clr);
        @(posedge clk);
        #1;
        in_valid = v;
        in_d16   = 16'(x);
        ch_sync  = s;
        ovf_clr  = clr;
        if (v) push_sample(x, s);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rstn     = 1'b0;
        in_valid = 1'b0;
        ch_sync  = 1'b0;
        ovf_clr  = 1'b0;
        in_d16   = '0;
        #1;
        check("rst_valid", {a_vld, b_vld, c_vld, d_vld}, 0);
        check("rst_data_a", $signed(a_dat), 0);
        check("rst_data_b", $signed(b_dat), 0);
        check("rst_data_c", $signed(c_dat), 0);
        check("rst_data_d", $signed(d_dat), 0);
        check("rst_ch", {a_ch, b_ch, c_ch, d_ch}, 0);
        check("rst_ovf", {a_ovf, b_ovf, c_ovf, d_ovf}, 0);
        sb.delete();
        foreach (xh[i, c, k]) xh[i][c][k] = 0;
        foreach (m_cnt[i]) begin
            m_cnt[i]  = 0;
            last_d[i] = 0;
            last_c[i] = 0;
        end
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        #2 rstn = 1'b0;
        do_reset();

        // Two channels: 10,20,13,25 -> C gives 10,20,3,5.
        step(1, 10, 1, 0);
        step(1, 20, 0, 0);
        step(1, 13, 0, 0);
        step(1, 25, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        do_reset();

        // Back-to-back 5,7,7,3 -> A gives 5,2,0,-4.
        step(1, 5, 1, 0);
        step(1, 7, 0, 0);
        step(1, 7, 0, 0);
        step(1, 3, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        do_reset();

        // 127 then -128: wrap gives 1, saturate gives -128, both flag overflow.
        step(1, 127, 0, 0);
        step(1, -128, 0, 0);
        check("ovf_before_a", a_ovf, 0);
        step(0, 0, 0, 0);
        check("ovf_set_a", a_ovf, 1);
        check("ovf_set_b", b_ovf, 1);
        check("ovf_wide_cd", {c_ovf, d_ovf}, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("ovf_clr_a", a_ovf, 0);
        check("ovf_clr_b", b_ovf, 0);
        // New overflow coincident with clear keeps the flag set.
        step(1, 127, 0, 1);
        step(0, 0, 0, 0);
        check("ovf_setclr_a", a_ovf, 1);
        check("ovf_setclr_b", b_ovf, 1);
        repeat (4) step(0, 0, 0, 0);
        do_reset();

        // Reset with two samples in flight, then a gapped impulse into the 3-stage M=2 chain.
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        do_reset();
        step(1, 1, 1, 0);
        for (int k = 0; k < 6; k++) begin
            repeat (k % 2 + 1) step(0, 0, 0, 0);
            step(1, 0, 0, 0);
        end
        repeat (8) step(0, 0, 0, 0);
        check("ovf_impulse_d", d_ovf, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
